// File: rtl/intr_pkg.sv
// Shared types and register map for the prioritised interrupt controller.
package intr_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERV
  } intr_state_e;

  localparam logic [1:0] INTR_PEND = 2'd0;
  localparam logic [1:0] INTR_MASK = 2'd1;
  localparam logic [1:0] INTR_ID   = 2'd2;
  localparam logic [1:0] INTR_EOI  = 2'd3;

  localparam int ID_VALID_BIT = 31;
endpackage

// File: rtl/prio_encoder.sv
// Combinational lowest-index-wins priority encoder.
module prio_encoder #(
  parameter int N_SRC = 8,
  parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req_vec,
  output logic [ID_W-1:0]  idx,
  output logic             any
);
  always_comb begin
    idx = '0;
    any = |req_vec;
    // scan downward so the lowest set bit is assigned last
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_vec[i]) idx = ID_W'(i);
    end
  end
endmodule

// File: rtl/intr_controller.sv
// Edge-latched, masked, prioritised interrupt controller on the IO bus.
module intr_controller
  import intr_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             int_ack,
  output logic             intr,
  input  logic             io_cs,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [1:0]       io_addr,
  input  logic [31:0]      io_wdata,
  output logic [31:0]      io_rdata
);
  intr_state_e state_q, state_d;

  logic [N_SRC-1:0] irq_q, irq_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             id_valid_q, id_valid_d;
  logic             intr_q, intr_d;

  logic [N_SRC-1:0] edge_set;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] w1c_clr;
  logic [ID_W-1:0]  win_idx;
  logic             req;
  logic             wr_en;
  logic             eoi_wr;
  logic             ack_take;
  logic             unused_wdata;

  assign unused_wdata = ^io_wdata;

  prio_encoder #(
    .N_SRC(N_SRC),
    .ID_W (ID_W)
  ) u_prio (
    .req_vec(pend_q & mask_q),
    .idx    (win_idx),
    .any    (req)
  );

  assign edge_set = irq_in & ~irq_q;
  assign wr_en    = io_cs & io_wr;
  assign eoi_wr   = wr_en & (io_addr == INTR_EOI);
  assign ack_take = (state_q == ST_REQ) & int_ack & req;
  assign irq_d    = irq_in;

  always_comb begin
    w1c_clr = '0;
    if (wr_en && io_addr == INTR_PEND) w1c_clr = io_wdata[N_SRC-1:0];
    ack_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      ack_clr[i] = ack_take & (win_idx == ID_W'(i));
    end
    // new edges win over both clear sources
    pend_d = (pend_q & ~w1c_clr & ~ack_clr) | edge_set;
    mask_d = mask_q;
    if (wr_en && io_addr == INTR_MASK) mask_d = io_wdata[N_SRC-1:0];
  end

  always_comb begin
    state_d    = state_q;
    intr_d     = intr_q;
    id_d       = id_q;
    id_valid_d = id_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        intr_d = 1'b0;
        if (req) begin
          state_d = ST_REQ;
          intr_d  = 1'b1;
        end
      end
      ST_REQ: begin
        intr_d = 1'b1;
        if (int_ack && req) begin
          state_d    = ST_SERV;
          intr_d     = 1'b0;
          id_d       = win_idx;
          id_valid_d = 1'b1;
        end else if (int_ack) begin
          state_d    = ST_IDLE;
          intr_d     = 1'b0;
          id_d       = '0;
          id_valid_d = 1'b0;
        end else if (!req) begin
          state_d = ST_IDLE;
          intr_d  = 1'b0;
        end
      end
      ST_SERV: begin
        intr_d = 1'b0;
        if (eoi_wr) begin
          state_d    = ST_IDLE;
          id_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        intr_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      irq_q      <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      id_q       <= '0;
      id_valid_q <= 1'b0;
      intr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_q      <= irq_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      id_q       <= id_d;
      id_valid_q <= id_valid_d;
      intr_q     <= intr_d;
    end
  end

  assign intr = intr_q;

  always_comb begin
    io_rdata = '0;
    if (io_cs && io_rd) begin
      unique case (io_addr)
        INTR_PEND: io_rdata[N_SRC-1:0] = pend_q;
        INTR_MASK: io_rdata[N_SRC-1:0] = mask_q;
        INTR_ID: begin
          io_rdata[ID_VALID_BIT] = id_valid_q;
          io_rdata[ID_W-1:0]     = id_q;
        end
        default: io_rdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_intr_controller.sv
// Directed bench for intr_controller.
module tb_intr_controller;
  logic        sys_clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  irq_in = '0;
  logic        int_ack = 1'b0;
  logic        intr;
  logic        io_cs = 1'b0;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [1:0]  io_addr = '0;
  logic [31:0] io_wdata = '0;
  logic [31:0] io_rdata;

  int n_cmp = 0;
  int n_err = 0;

  intr_controller #(.N_SRC(8), .ID_W(3)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .int_ack (int_ack),
    .intr    (intr),
    .io_cs   (io_cs),
    .io_rd   (io_rd),
    .io_wr   (io_wr),
    .io_addr (io_addr),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    io_cs = 1'b1; io_wr = 1'b1; io_addr = a; io_wdata = d;
    tick();
    io_cs = 1'b0; io_wr = 1'b0; io_wdata = '0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a,
                    input logic [31:0] exp);
    io_cs = 1'b1; io_rd = 1'b1; io_addr = a;
    #1;
    chk(tag, io_rdata, exp);
    io_cs = 1'b0; io_rd = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    @(negedge sys_clk);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_intr", {31'd0, intr}, 32'd0);
    rd("rst_pend", 2'd0, 32'h0);
    rd("rst_mask", 2'd1, 32'h0);
    rd("rst_id", 2'd2, 32'h0);
    rd("rst_eoi", 2'd3, 32'h0);
    io_addr = 2'd1; #1;
    chk("rdata_idle", io_rdata, 32'h0);

    // masked edge only latches PEND
    irq_in = 8'h04; tick(); irq_in = 8'h00;
    rd("masked_pend", 2'd0, 32'h04);
    tick();
    chk("masked_intr", {31'd0, intr}, 32'd0);
    wr(2'd0, 32'h04);
    rd("w1c_pend", 2'd0, 32'h0);

    // single source latency, ack, EOI
    wr(2'd1, 32'hFF);
    rd("mask_ff", 2'd1, 32'hFF);
    irq_in = 8'h20; tick();
    chk("lat_k", {31'd0, intr}, 32'd0);
    tick();
    chk("lat_k1", {31'd0, intr}, 32'd1);
    ack();
    chk("ack5_intr", {31'd0, intr}, 32'd0);
    rd("ack5_id", 2'd2, 32'h80000005);
    rd("ack5_pend", 2'd0, 32'h0);
    wr(2'd3, 32'h0);
    rd("eoi5_id", 2'd2, 32'h00000005);
    tick();
    chk("eoi5_idle", {31'd0, intr}, 32'd0);
    irq_in = 8'h00; tick();

    // two sources, lowest index first
    irq_in = 8'h42; tick(); irq_in = 8'h00;
    tick();
    chk("two_req", {31'd0, intr}, 32'd1);
    ack();
    rd("two_id1", 2'd2, 32'h80000001);
    rd("two_pend", 2'd0, 32'h40);
    wr(2'd3, 32'h0);
    chk("two_eoi_e", {31'd0, intr}, 32'd0);
    tick();
    chk("two_eoi_e1", {31'd0, intr}, 32'd1);
    ack();
    rd("two_id6", 2'd2, 32'h80000006);
    wr(2'd3, 32'h0);
    rd("two_pend0", 2'd0, 32'h0);

    // mask drop in REQ, then spurious ack
    irq_in = 8'h01; tick(); irq_in = 8'h00;
    tick();
    chk("m0_req", {31'd0, intr}, 32'd1);
    wr(2'd1, 32'h00);
    tick();
    chk("m0_drop", {31'd0, intr}, 32'd0);
    wr(2'd1, 32'hFF);
    tick();
    chk("m0_rereq", {31'd0, intr}, 32'd1);
    wr(2'd0, 32'h01);
    ack();
    rd("spur_id", 2'd2, 32'h0);
    chk("spur_intr", {31'd0, intr}, 32'd0);

    // ack held in SERV, edge during SERV stays pending
    irq_in = 8'h10; tick(); irq_in = 8'h00;
    tick();
    ack();
    rd("serv_id4", 2'd2, 32'h80000004);
    int_ack = 1'b1; irq_in = 8'h08;
    tick(); tick(); tick();
    int_ack = 1'b0; irq_in = 8'h00;
    rd("hold_id", 2'd2, 32'h80000004);
    rd("hold_pend", 2'd0, 32'h08);
    chk("hold_intr", {31'd0, intr}, 32'd0);
    wr(2'd3, 32'h0);
    chk("hold_eoi_e", {31'd0, intr}, 32'd0);
    tick();
    chk("hold_eoi_e1", {31'd0, intr}, 32'd1);
    ack();
    rd("hold_id3", 2'd2, 32'h80000003);
    wr(2'd3, 32'h0);

    // edge beats W1C on the same bit
    wr(2'd1, 32'h00);
    irq_in = 8'h04; tick(); irq_in = 8'h00;
    tick();
    rd("w1c_pre", 2'd0, 32'h04);
    irq_in = 8'h04;
    wr(2'd0, 32'h04);
    irq_in = 8'h00;
    rd("w1c_edge", 2'd0, 32'h04);

    // reset while in REQ
    wr(2'd1, 32'hFF);
    tick();
    chk("pre_rst_req", {31'd0, intr}, 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_intr", {31'd0, intr}, 32'd0);
    rd("mid_rst_pend", 2'd0, 32'h0);
    rd("mid_rst_mask", 2'd1, 32'h0);
    rd("mid_rst_id", 2'd2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
